// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared definitions for the 8-bit toy SPN decryptor.
//   - ROUNDS_DEFAULT : default number of SPN rounds
//   - CNT_W          : width of the round counter (covers ROUNDS up to 7)
//   - SBOX/INV_SBOX  : PRESENT 4-bit S-box and its inverse
//   - rotl8/rotr8    : 8-bit rotates
//   - round_key      : K_r = rotl8(key, r)
//   - state_e        : controller states
package decrypt_pkg;

  localparam int unsigned ROUNDS_DEFAULT = 3;
  localparam int unsigned CNT_W          = 3;

  // Forward S-box. The decryptor never uses it; it is kept next to its
  // inverse so both tables live in one place.
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Rotate left by n (0..7): the upper byte of the doubled word shifted left.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Rotate right by n (0..7): the lower byte of the doubled word shifted right.
  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} >> n;
    return d[7:0];
  endfunction

  function automatic logic [7:0] round_key(input logic [7:0] key, input logic [2:0] r);
    return rotl8(key, r);
  endfunction

endpackage

// File: rtl/decrypt_sbox4_inv.sv
// sbox4_inv: combinational 4-bit inverse PRESENT S-box.
//   nib_i : 4-bit input nibble
//   nib_o : inverse S-box of nib_i
module sbox4_inv
  import decrypt_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = INV_SBOX[nib_i];
  end

endmodule

// File: rtl/decrypt.sv
// decrypt: iterative 8-bit decryptor for the toy 3-round PRESENT-S-box SPN.
// One round is undone per clock; a result appears ROUNDS cycles after start.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   start : request pulse, accepted only when busy=0
//   key   : cipher key, captured on the accepted start
//   inp   : ciphertext byte, captured on the accepted start
//   out   : registered plaintext, held until the next completion
//   valid : one-cycle pulse marking a new out value
//   busy  : high while a decryption is in progress
module decrypt
  import decrypt_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] key,
  input  logic [7:0] inp,
  output logic [7:0] out,
  output logic       valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LastKeyIdx  = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0] FirstRound  = CNT_W'(ROUNDS - 1);

  state_e           fsm_q,   fsm_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [7:0]       key_q,   key_d;
  logic [7:0]       data_q,  data_d;
  logic [7:0]       out_q,   out_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;

  // Datapath for one inverse round: rotr1 -> InvS on both nibbles -> ^K_round.
  logic [7:0] rot_data;
  logic [7:0] inv_data;
  logic [7:0] round_out;

  assign rot_data = rotr8(data_q, 3'd1);

  sbox4_inv u_inv_hi (
    .nib_i (rot_data[7:4]),
    .nib_o (inv_data[7:4])
  );

  sbox4_inv u_inv_lo (
    .nib_i (rot_data[3:0]),
    .nib_o (inv_data[3:0])
  );

  assign round_out = inv_data ^ round_key(key_q, round_q);

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    key_d   = key_q;
    data_d  = data_q;
    out_d   = out_q;
    valid_d = 1'b0;
    busy_d  = busy_q;

    unique case (fsm_q)
      StIdle: begin
        if (start) begin
          // Strip the final whitening key using the live key, not key_q,
          // since key_q only takes the new key at this same edge.
          key_d   = key;
          data_d  = inp ^ round_key(key, LastKeyIdx);
          round_d = FirstRound;
          busy_d  = 1'b1;
          fsm_d   = StRun;
        end
      end
      StRun: begin
        data_d = round_out;
        if (round_q != '0) begin
          round_d = round_q - 1'b1;
        end else begin
          out_d   = round_out;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          fsm_d   = StIdle;
        end
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIdle;
      round_q <= '0;
      key_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      key_q   <= key_d;
      data_q  <= data_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_decrypt.sv
// tb_decrypt: self-checking bench for decrypt (ROUNDS = 3).
// Reference model: straight-line decrypt/encrypt from the cipher definition,
// with the inverse S-box derived here by inverting the forward table.
module tb_decrypt;
  import decrypt_pkg::*;

  localparam int NR = 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] key;
  logic [7:0] inp;
  logic [7:0] out;
  logic       valid;
  logic       busy;

  int n_tests;
  int n_fail;

  logic [3:0] m_sbox [16];
  logic [3:0] m_inv  [16];

  decrypt #(
    .ROUNDS (NR)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .inp   (inp),
    .out   (out),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_rotl(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  function automatic logic [7:0] m_dec(input logic [7:0] ct, input logic [7:0] k);
    logic [7:0] x;
    x = ct ^ m_rotl(k, NR);
    for (int r = NR - 1; r >= 0; r--) begin
      x = {x[0], x[7:1]};
      x = {m_inv[x[7:4]], m_inv[x[3:0]]};
      x = x ^ m_rotl(k, r);
    end
    return x;
  endfunction

  function automatic logic [7:0] m_enc(input logic [7:0] pt, input logic [7:0] k);
    logic [7:0] x;
    x = pt;
    for (int r = 0; r < NR; r++) begin
      x = x ^ m_rotl(k, r);
      x = {m_sbox[x[7:4]], m_sbox[x[3:0]]};
      x = m_rotl(x, 1);
    end
    return x ^ m_rotl(k, NR);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start through an edge, then scramble key/inp.
  task automatic do_start(input logic [7:0] ct, input logic [7:0] k);
    start = 1'b1;
    inp   = ct;
    key   = k;
    step();
    start = 1'b0;
    inp   = 8'($urandom);
    key   = 8'($urandom);
  endtask

  // Cycles until valid is seen (bounded); -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    key   = 8'h3C;
    inp   = 8'h86;
    step();
    step();
    n_tests++;
    if ({out, valid, busy} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: out=%h valid=%b busy=%b, want out=00 valid=0 busy=0",
               out, valid, busy);
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    n_tests++;
    if ({valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b busy=%b, want 0 0", valid, busy);
    end
  endtask

  task automatic test_single();
    do_start(8'h86, 8'h3C);
    for (int i = 1; i <= NR; i++) begin
      n_tests++;
      if ({valid, busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL single_busy[%0d]: valid=%b busy=%b, want 0 1", i, valid, busy);
      end
      step();
    end
    n_tests++;
    if ({valid, busy, out} !== {1'b1, 1'b0, 8'hCA}) begin
      n_fail++;
      $display("FAIL single_done: valid=%b busy=%b out=%h, want 1 0 CA", valid, busy, out);
    end
    step();
    n_tests++;
    if ({valid, out} !== {1'b0, 8'hCA}) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b out=%h, want 0 CA", valid, out);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] cts [4];
    logic [7:0] exp [4];
    int n;
    cts = '{8'h1B, 8'h47, 8'h09, 8'h26};
    exp = '{8'hD7, 8'h23, 8'hFB, 8'hEA};
    for (int i = 0; i < 4; i++) begin
      do_start(cts[i], 8'h3C);
      wait_valid(n);
      n_tests++;
      if (n != NR || out !== exp[i]) begin
        n_fail++;
        $display("FAIL seq[%0d]: latency=%0d out=%h, want latency=%0d out=%h",
                 i, n, out, NR, exp[i]);
      end
      n_tests++;
      if (out !== m_dec(cts[i], 8'h3C)) begin
        n_fail++;
        $display("FAIL seq_model[%0d]: out=%h, want %h", i, out, m_dec(cts[i], 8'h3C));
      end
    end
  endtask

  task automatic test_ignored_start();
    int nv;
    int first;
    logic [7:0] vout;
    step();
    do_start(8'h1B, 8'h3C);
    start = 1'b1;
    inp   = 8'h47;
    key   = 8'h3C;
    step();
    start = 1'b0;
    nv    = 0;
    first = -1;
    vout  = 8'h00;
    if (valid === 1'b1) begin
      nv++;
      first = 1;
    end
    for (int i = 2; i <= 12; i++) begin
      step();
      if (valid === 1'b1) begin
        nv++;
        if (first < 0) begin
          first = i;
          vout  = out;
        end
      end
    end
    n_tests++;
    if (nv != 1 || first != NR || vout !== 8'hD7) begin
      n_fail++;
      $display("FAIL ignored_start: valids=%0d at=%0d out=%h, want 1 at %0d out=D7",
               nv, first, vout, NR);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(8'h09, 8'h3C);
    wait_valid(n);
    n_tests++;
    if (n != NR || out !== 8'hFB) begin
      n_fail++;
      $display("FAIL b2b_first: latency=%0d out=%h, want %0d FB", n, out, NR);
    end
    // Start in the valid cycle.
    do_start(8'h26, 8'h3C);
    for (int i = 1; i < NR + 1; i++) begin
      n_tests++;
      if ({valid, out, busy} !== {1'b0, 8'hFB, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_hold[%0d]: valid=%b out=%h busy=%b, want 0 FB 1",
                 i, valid, out, busy);
      end
      if (i < NR) step();
    end
    step();
    n_tests++;
    if ({valid, out} !== {1'b1, 8'hEA}) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b out=%h, want 1 EA (4 cycles after first)",
               valid, out);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    int n;
    step();
    do_start(8'h86, 8'h3C);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({out, valid, busy} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: out=%h valid=%b busy=%b, want 00 0 0", out, valid, busy);
    end
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid === 1'b1) nv++;
    end
    n_tests++;
    if (nv != 0 || out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_novalid: valids=%0d out=%h, want 0 00", nv, out);
    end
    do_start(8'h86, 8'h3C);
    wait_valid(n);
    n_tests++;
    if (n != NR || out !== 8'hCA) begin
      n_fail++;
      $display("FAIL reset_mid_restart: latency=%0d out=%h, want %0d CA", n, out, NR);
    end
  endtask

  task automatic test_random();
    logic [7:0] ct;
    logic [7:0] k;
    int n;
    for (int t = 0; t < 40; t++) begin
      ct = 8'($urandom);
      k  = 8'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      do_start(ct, k);
      // Extra start while busy with garbage must be ignored.
      if ($urandom_range(0, 1) == 1) start = 1'b1;
      wait_valid(n);
      start = 1'b0;
      n_tests++;
      if (n != NR || out !== m_dec(ct, k)) begin
        n_fail++;
        $display("FAIL random[%0d] ct=%h key=%h: latency=%0d out=%h, want %0d %h",
                 t, ct, k, n, out, NR, m_dec(ct, k));
      end
      n_tests++;
      if (m_enc(out, k) !== ct) begin
        n_fail++;
        $display("FAIL random_roundtrip[%0d]: enc(out=%h)=%h, want ct=%h",
                 t, out, m_enc(out, k), ct);
      end
      step();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) m_sbox[i] = SBOX[i];
    for (int i = 0; i < 16; i++) m_inv[m_sbox[i]] = 4'(i);
    rst   = 1'b0;
    start = 1'b0;
    key   = 8'h00;
    inp   = 8'h00;

    test_reset();
    test_single();
    test_sequence();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
